// File: rtl/pam4_isi_channel.sv
// pam4_isi_channel: FIR ISI channel with optional LFSR noise and output saturation for PAM-4 sample streams.
module pam4_isi_channel #(
  parameter int SIGNAL_RESOLUTION = 8,
  parameter int NUM_TAPS = 4,
  parameter int TAP_WIDTH = 8,
  parameter int TAP_FRAC = 6,
  parameter int NOISE_BITS = 3,
  localparam int AW = NUM_TAPS > 1 ? $clog2(NUM_TAPS) : 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic signed [SIGNAL_RESOLUTION-1:0] voltage_level_in,
  input  logic                                voltage_level_in_valid,
  input  logic                                tap_wr_en,
  input  logic [AW-1:0]                       tap_addr,
  input  logic signed [TAP_WIDTH-1:0]         tap_data,
  input  logic                                noise_en,
  output logic signed [SIGNAL_RESOLUTION-1:0] voltage_level_out,
  output logic                                voltage_level_out_valid
);
  localparam int SR = SIGNAL_RESOLUTION;
  localparam int PW = SR + TAP_WIDTH;
  localparam int ACCW = PW + $clog2(NUM_TAPS);
  localparam logic signed [ACCW:0] MAXV = (ACCW+1)'((2 ** (SR - 1)) - 1);
  localparam logic signed [ACCW:0] MINV = (ACCW+1)'(-(2 ** (SR - 1)));
  localparam logic signed [TAP_WIDTH-1:0] UNITY = TAP_WIDTH'(1 << TAP_FRAC);
  logic signed [SR-1:0] x_q [NUM_TAPS];
  logic signed [SR-1:0] x_d [NUM_TAPS];
  logic signed [TAP_WIDTH-1:0] h_q [NUM_TAPS];
  logic signed [TAP_WIDTH-1:0] h_d [NUM_TAPS];
  logic signed [PW-1:0] p_q [NUM_TAPS];
  logic signed [PW-1:0] p_d [NUM_TAPS];
  logic signed [NOISE_BITS-1:0] n_q, n_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic v1_q, v2_q;
  logic signed [SR-1:0] out_q, out_d;
  logic signed [ACCW-1:0] acc;
  logic signed [ACCW:0] res;
  // products use the freshly shifted history but the coefficients from before any same-cycle write
  always_comb begin
    x_d = x_q;
    h_d = h_q;
    p_d = p_q;
    n_d = n_q;
    lfsr_d = lfsr_q;
    acc = '0;
    if (voltage_level_in_valid) begin
      x_d[0] = voltage_level_in;
      for (int k = 1; k < NUM_TAPS; k++) x_d[k] = x_q[k-1];
      for (int k = 0; k < NUM_TAPS; k++) p_d[k] = PW'(x_d[k]) * PW'(h_q[k]);
      n_d = noise_en ? NOISE_BITS'(lfsr_q) : '0;
      lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end
    if (tap_wr_en && 32'(tap_addr) < NUM_TAPS) h_d[tap_addr] = tap_data;
    for (int k = 0; k < NUM_TAPS; k++) acc = acc + ACCW'(p_q[k]);
    res = (ACCW+1)'(acc >>> TAP_FRAC) + (ACCW+1)'(n_q);
    out_d = res > MAXV ? SR'(MAXV) : res < MINV ? SR'(MINV) : SR'(res);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        x_q[k] <= '0;
        p_q[k] <= '0;
        h_q[k] <= '0;
      end
      h_q[0] <= UNITY;
      n_q <= '0;
      lfsr_q <= 16'hACE1;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      out_q <= '0;
    end else begin
      x_q <= x_d;
      h_q <= h_d;
      p_q <= p_d;
      n_q <= n_d;
      lfsr_q <= lfsr_d;
      v1_q <= voltage_level_in_valid;
      v2_q <= v1_q;
      if (v1_q) out_q <= out_d;
    end
  end
  assign voltage_level_out = out_q;
  assign voltage_level_out_valid = v2_q;
endmodule
